// File: rtl/ring_decoder.sv
// ring_decoder
// Decodes a one-hot word that rotates right by one bit on every accepted sample.
// It also tracks whether the rotation stays in sequence:
//   - HUNT waits for any one-hot sample.
//   - SYNC counts LOCK_CNT consecutive correct rotations.
//   - LOCKED holds as long as the rotation stays correct.
// Losing lock raises a one-cycle err pulse and bumps a saturating error counter.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   ring_in carries a sample this cycle
//   ring_in    ring word (legal values are one-hot)
//   idx        bit position of the last valid one-hot sample
//   idx_valid  idx was refreshed from a one-hot sample on the last edge
//   locked     decoder is in LOCKED
//   err        one-cycle pulse on loss of lock
//   err_count  saturating count of err pulses
//
// state  | meaning
// HUNT   | no reference word; waiting for any one-hot sample
// SYNC   | reference held; counting consecutive correct rotations in mcnt
// LOCKED | rotation confirmed; any other sample drops lock and pulses err
module ring_decoder #(
    parameter int WIDTH    = 4,
    parameter int IDX_W    = 2,
    parameter int LOCK_CNT = 2,
    parameter int ERRC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  ring_in,
    output logic [IDX_W-1:0]  idx,
    output logic              idx_valid,
    output logic              locked,
    output logic              err,
    output logic [ERRC_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       mcnt;

    logic             is_onehot;
    logic             match;
    logic [IDX_W-1:0] enc;
    logic [WIDTH-1:0] expect_word;
    logic [3:0]       mcnt_inc;

    always_comb begin
        // Clearing the lowest set bit leaves zero only for a single-bit word.
        is_onehot   = (ring_in != '0) && ((ring_in & (ring_in - 1'b1)) == '0);
        expect_word = {prev[0], prev[WIDTH-1:1]};
        // prev is zero out of reset, so expect_word is zero and can never match a legal sample.
        match       = is_onehot && (ring_in == expect_word);
        mcnt_inc    = mcnt + 4'd1;
        enc         = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) begin
                enc = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            prev      <= '0;
            mcnt      <= '0;
            idx       <= '0;
            idx_valid <= 1'b0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            idx_valid <= 1'b0;
            err       <= 1'b0;
            if (in_valid) begin
                if (is_onehot) begin
                    idx       <= enc;
                    idx_valid <= 1'b1;
                    prev      <= ring_in;
                end
                case (state)
                    HUNT: begin
                        if (is_onehot) begin
                            state <= SYNC;
                            mcnt  <= '0;
                        end
                    end
                    SYNC: begin
                        if (!is_onehot) begin
                            state <= HUNT;
                            mcnt  <= '0;
                        end else if (match) begin
                            if (mcnt_inc == LOCK_TGT) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                mcnt   <= '0;
                            end else begin
                                mcnt <= mcnt_inc;
                            end
                        end else begin
                            mcnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!match) begin
                            err    <= 1'b1;
                            locked <= 1'b0;
                            mcnt   <= '0;
                            state  <= is_onehot ? SYNC : HUNT;
                            // Once saturated, the count stops while err keeps pulsing.
                            if (err_count != '1) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        mcnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// Testbench for ring_decoder.
// A behavioural model tracks a reference word and the length of the current
// run of correct rotations. Lock means the run has reached LOCK_CNT.
// Two instances share one stimulus stream: one uses the default counter width,
// and one uses a 2-bit counter so that saturation is reachable.
module tb_ring_decoder;

    localparam int W  = 4;
    localparam int IW = 2;
    localparam int LC = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  ring_in = '0;

    logic [IW-1:0] idx, idx2;
    logic          idx_valid, idx_valid2;
    logic          locked, locked2;
    logic          err, err2;
    logic [7:0]    err_count;
    logic [1:0]    err_count2;

    int vectors = 0;
    int miscompares = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    ring_decoder #(.WIDTH(W), .IDX_W(IW), .LOCK_CNT(LC), .ERRC_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in),
        .idx(idx), .idx_valid(idx_valid), .locked(locked), .err(err),
        .err_count(err_count)
    );

    ring_decoder #(.WIDTH(W), .IDX_W(IW), .LOCK_CNT(LC), .ERRC_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ring_in(ring_in),
        .idx(idx2), .idx_valid(idx_valid2), .locked(locked2), .err(err2),
        .err_count(err_count2)
    );

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_ref, n_ref;
    logic         m_have, n_have;
    int           m_run, n_run;
    int           m_errs, n_errs;
    int           m_idx, n_idx;
    logic         m_idx_valid, n_idx_valid;
    logic         m_err, n_err;

    function automatic logic [W-1:0] rot(input logic [W-1:0] p);
        return (p >> 1) | (p << (W - 1));
    endfunction

    function automatic int pos_of(input logic [W-1:0] s);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            if (s == (W'(1) << i)) r = i;
        end
        return r;
    endfunction

    always_comb begin
        logic hot;
        logic good;
        n_ref       = m_ref;
        n_have      = m_have;
        n_run       = m_run;
        n_errs      = m_errs;
        n_idx       = m_idx;
        n_idx_valid = 1'b0;
        n_err       = 1'b0;
        hot         = ($countones(ring_in) == 1);
        good        = hot && m_have && (ring_in == rot(m_ref));
        if (in_valid) begin
            if (!good && m_run >= LC) begin
                n_err  = 1'b1;
                n_errs = m_errs + 1;
            end
            if (good) begin
                n_run = (m_run < 100) ? m_run + 1 : m_run;
            end else begin
                n_run  = 0;
                n_have = hot;
            end
            if (hot) begin
                n_ref       = ring_in;
                n_idx       = pos_of(ring_in);
                n_idx_valid = 1'b1;
            end
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ref <= '0; m_have <= 1'b0; m_run <= 0; m_errs <= 0;
            m_idx <= 0; m_idx_valid <= 1'b0; m_err <= 1'b0;
        end else begin
            m_ref <= n_ref; m_have <= n_have; m_run <= n_run; m_errs <= n_errs;
            m_idx <= n_idx; m_idx_valid <= n_idx_valid; m_err <= n_err;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("idx", int'(idx), m_idx);
            chk("idx_valid", int'(idx_valid), int'(m_idx_valid));
            chk("locked", int'(locked), (m_run >= LC) ? 1 : 0);
            chk("err", int'(err), int'(m_err));
            chk("err_count", int'(err_count), (m_errs > 255) ? 255 : m_errs);
            chk("idx_2", int'(idx2), m_idx);
            chk("locked_2", int'(locked2), (m_run >= LC) ? 1 : 0);
            chk("err_2", int'(err2), int'(m_err));
            chk("err_count_2", int'(err_count2), (m_errs > 3) ? 3 : m_errs);
        end
    end

    task automatic apply(input logic v, input logic [W-1:0] w);
        in_valid = v;
        ring_in  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_idx"}, int'(idx), 0);
        chk({tag, "_idx_valid"}, int'(idx_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_err_count"}, int'(err_count), 0);
        chk({tag, "_err_count_2"}, int'(err_count2), 0);
    endtask

    initial begin
        logic [W-1:0] lasthot;
        logic [W-1:0] w;
        logic         v;
        int           r;

        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // acquire lock: 1000, 0100, 0010
        apply(1'b1, 4'b1000); chk("acq_idx3", int'(idx), 3); chk("acq_locked0", int'(locked), 0);
        apply(1'b1, 4'b0100); chk("acq_idx2", int'(idx), 2);
        apply(1'b1, 4'b0010); chk("acq_idx1", int'(idx), 1); chk("acq_locked1", int'(locked), 1);
        chk("acq_err0", int'(err), 0);

        // wrap around bit 0
        apply(1'b1, 4'b0001); chk("wrap_idx0", int'(idx), 0);
        apply(1'b1, 4'b1000); chk("wrap_idx3", int'(idx), 3); chk("wrap_locked", int'(locked), 1);
        chk("wrap_errc", int'(err_count), 0);

        // repeated word drops lock into SYNC
        apply(1'b1, 4'b0100);
        apply(1'b1, 4'b0010);
        apply(1'b1, 4'b0010); chk("rep_err", int'(err), 1); chk("rep_errc", int'(err_count), 1);
        chk("rep_locked", int'(locked), 0);
        apply(1'b1, 4'b0001); chk("rep_err_clr", int'(err), 0); chk("rep_still_unlocked", int'(locked), 0);
        apply(1'b1, 4'b1000); chk("relock", int'(locked), 1);

        // idle cycles with garbage on the bus
        repeat (5) begin
            apply(1'b0, 4'b1111);
            chk("idle_iv", int'(idx_valid), 0); chk("idle_err", int'(err), 0);
            chk("idle_locked", int'(locked), 1); chk("idle_idx", int'(idx), 3);
        end
        apply(1'b1, 4'b0100); chk("resume_locked", int'(locked), 1); chk("resume_idx", int'(idx), 2);

        // multi-bit word drops to HUNT
        apply(1'b1, 4'b0110); chk("ill_err", int'(err), 1); chk("ill_errc", int'(err_count), 2);
        chk("ill_idx_hold", int'(idx), 2); chk("ill_iv", int'(idx_valid), 0);
        chk("ill_locked", int'(locked), 0);
        apply(1'b1, 4'b0000); chk("zero_err", int'(err), 0); chk("zero_locked", int'(locked), 0);

        // three more lock losses: the 2-bit counter saturates at 3
        repeat (3) begin
            apply(1'b1, 4'b1000); apply(1'b1, 4'b0100); apply(1'b1, 4'b0010);
            apply(1'b1, 4'b0000);
            chk("sat_err_pulse", int'(err2), 1);
        end
        chk("sat_errc2", int'(err_count2), 3);
        chk("sat_errc8", int'(err_count), 5);

        // asynchronous reset in the middle of a locked stream
        apply(1'b1, 4'b1000); apply(1'b1, 4'b0100); apply(1'b1, 4'b0010);
        chk("pre_rst_locked", int'(locked), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        apply(1'b1, 4'b0001); chk("post_rst_idx", int'(idx), 0); chk("post_rst_locked", int'(locked), 0);

        // randomized stream
        lasthot = 4'b0001;
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 7)       w = rot(lasthot);
            else if (r == 7) w = lasthot;
            else if (r == 8) w = W'(1) << $urandom_range(0, W - 1);
            else             w = W'($urandom_range(0, 15));
            if (v && $countones(w) == 1) lasthot = w;
            if (n == 1500) begin
                rst = 1'b1;
                #1 chk_all_zero("rand_rst");
                @(negedge clk);
                rst = 1'b0;
            end
            apply(v, w);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
